// File: rtl/megarom_pkg.sv
// ---------------------------------------------------------------------------
// megarom_pkg
// Shared definitions for the MegaROM SPI master: command encodings, the fixed
// lock/unlock frames and the master FSM state enumeration.
// ---------------------------------------------------------------------------
package megarom_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE  = 2'b00,
        CMD_READ   = 2'b01,
        CMD_LOCK   = 2'b10,   // take flash from the BBC
        CMD_UNLOCK = 2'b11    // return flash to the BBC
    } cmd_t;

    localparam logic [31:0] LOCK_FRAME   = 32'hFFFF_FF00;
    localparam logic [31:0] UNLOCK_FRAME = 32'hFFFF_FFFF;
    localparam logic [5:0]  FRAME_BITS   = 6'd32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_HOLD = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

endpackage

// File: rtl/megarom_frame_builder.sv
// ---------------------------------------------------------------------------
// megarom_frame_builder
// Purely combinational mapping of a command to the 32-bit SPI frame.
// Ports:
//   cmd   - command encoding (write/read/lock/unlock)
//   addr  - 19-bit flash byte address (write/read only)
//   wdata - write data byte (write only)
//   frame - 32-bit frame, transmitted MSB first
// ---------------------------------------------------------------------------
module megarom_frame_builder
    import megarom_pkg::*;
(
    input  cmd_t        cmd,
    input  logic [18:0] addr,
    input  logic [7:0]  wdata,
    output logic [31:0] frame
);

    always_comb begin
        frame = UNLOCK_FRAME;
        case (cmd)
            CMD_WRITE:  frame = {addr, 1'b0, wdata, 4'b0000};
            CMD_READ:   frame = {addr, 1'b1, 12'h000};
            CMD_LOCK:   frame = LOCK_FRAME;
            CMD_UNLOCK: frame = UNLOCK_FRAME;
            default:    frame = UNLOCK_FRAME;
        endcase
    end

endmodule

// File: rtl/megarom_spi_master.sv
// ---------------------------------------------------------------------------
// megarom_spi_master
// SPI mode-0 master that sends one 32-bit command frame to the MegaROM CPLD
// per accepted request and returns the last 8 MISO bits of the frame.
//
// Handshake: a request is accepted in a cycle where req_valid and req_ready
// are both high; fields are captured into the transmit shift register in that
// cycle. req_ready is high only in IDLE, so requests offered at any other time
// are ignored (not queued). rsp_valid is a single-cycle pulse, coincident with
// spi_ss rising; rsp_rdata is valid then and held until the next completion.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake
//   req_cmd/addr/wdata    - request fields
//   rsp_valid/rsp_rdata   - completion pulse and received byte
//   spi_ss/sck/mosi/miso  - SPI pins (SS active low, SCK idles low)
//   dbg_state             - current FSM state, for observation only
// ---------------------------------------------------------------------------
module megarom_spi_master
    import megarom_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 1,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cmd,
    input  logic [18:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        spi_ss,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [2:0]  dbg_state
);

    localparam logic [7:0] HP_RELOAD  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYCLES - 1);

    state_t      state, state_d;
    logic [7:0]  hp_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] tx_sr;
    logic [7:0]  rx_sr;
    logic        ss_q, sck_q, ready_q, rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic [31:0] frame;

    logic handshake, phase_end, bit_exit, frame_done;

    megarom_frame_builder u_frame_builder (
        .cmd   (cmd_t'(req_cmd)),
        .addr  (req_addr),
        .wdata (req_wdata),
        .frame (frame)
    );

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_d    = state;
        phase_end  = (hp_cnt == 8'd0);
        handshake  = 1'b0;
        bit_exit   = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    handshake = 1'b1;
                    state_d   = ST_LOW;
                end
            end
            ST_LOW: begin
                if (phase_end) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (phase_end) begin
                    bit_exit = 1'b1;
                    // bit_cnt still counts the bit being finished here.
                    state_d  = (bit_cnt == 6'd1) ? ST_HOLD : ST_LOW;
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    frame_done = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (phase_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and registered outputs. Pin outputs are decoded from state_d
    // so they change on the same edge as the state and never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_cnt      <= 8'd0;
            bit_cnt     <= 6'd0;
            tx_sr       <= 32'd0;
            rx_sr       <= 8'd0;
            ss_q        <= 1'b1;
            sck_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
        end else begin
            // Every phase entry reloads the half-period counter.
            if (state_d != state) begin
                hp_cnt <= (state_d == ST_GAP) ? GAP_RELOAD : HP_RELOAD;
            end else if (hp_cnt != 8'd0) begin
                hp_cnt <= hp_cnt - 8'd1;
            end

            if (handshake) begin
                bit_cnt <= FRAME_BITS;
                tx_sr   <= frame;
            end else if (bit_exit) begin
                bit_cnt <= bit_cnt - 6'd1;
                // Next MOSI bit appears on the edge where SCK falls.
                tx_sr   <= {tx_sr[30:0], 1'b0};
                rx_sr   <= {rx_sr[6:0], spi_miso};
            end

            ss_q        <= !((state_d == ST_LOW) || (state_d == ST_HIGH) ||
                             (state_d == ST_HOLD));
            sck_q       <= (state_d == ST_HIGH);
            ready_q     <= (state_d == ST_IDLE);
            rsp_valid_q <= frame_done;
            if (frame_done) rsp_rdata_q <= rx_sr;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign spi_ss    = ss_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = tx_sr[31];
    assign dbg_state = state;

endmodule

// File: tb/tb_megarom_spi_master.sv
// ---------------------------------------------------------------------------
// tb_megarom_spi_master
// Directed bench for megarom_spi_master with a mode-0 slave model, a frame
// scoreboard (expected frames queued before each command), a running
// protocol monitor and a final report.
// ---------------------------------------------------------------------------
module tb_megarom_spi_master;

    localparam int HP  = 3;
    localparam int GAP = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_cmd   = 2'b00;
    logic [18:0] req_addr  = 19'd0;
    logic [7:0]  req_wdata = 8'd0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        spi_ss, spi_sck, spi_mosi, spi_miso;
    logic [2:0]  dbg_state;

    megarom_spi_master #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .spi_ss    (spi_ss),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .dbg_state (dbg_state)
    );

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    logic [31:0] miso_word = 32'd0;
    logic [31:0] slave_tx  = 32'd0;
    logic [31:0] cap       = 32'd0;
    int          cap_bits  = 0;

    always @(negedge spi_ss) begin
        cap      = 32'd0;
        cap_bits = 0;
        slave_tx = miso_word;
    end
    always @(posedge spi_sck) begin
        cap = {cap[30:0], spi_mosi};
        cap_bits++;
    end
    always @(negedge spi_sck) begin
        if (!spi_ss) slave_tx = {slave_tx[30:0], 1'b0};
    end
    assign spi_miso = slave_tx[31];

    // ---------------- scoreboard / monitor ----------------
    logic [31:0] exp_q[$];
    int  rsp_count = 0;
    int  proto_viol = 0;
    int  frame_len = 0;
    int  gap_len = 0;
    bit  gap_valid = 0;
    logic prev_ss = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_ss   = 1'b1;
            prev_sck  = 1'b0;
            prev_mosi = spi_mosi;
            frame_len = 0;
            gap_len   = 0;
            gap_valid = 0;
        end else begin
            if (prev_sck && spi_sck && (spi_mosi != prev_mosi)) proto_viol++;
            if (prev_ss && spi_ss && (spi_sck != prev_sck)) proto_viol++;
            if (rsp_valid) rsp_count++;
            if (!spi_ss) begin
                if (prev_ss) begin
                    if (gap_valid) check_eq("gap_min", 32'(gap_len >= GAP), 32'd1);
                    frame_len = 0;
                end
                frame_len++;
            end else begin
                if (!prev_ss) begin
                    check_eq("frame_len", 32'(frame_len), 32'(65 * HP));
                    check_eq("frame_bits", 32'(cap_bits), 32'd32);
                    check_eq("rsp_pulse", 32'(rsp_valid), 32'd1);
                    if (exp_q.size() == 0) check_eq("frame_unexpected", cap, 32'hxxxx_xxxx);
                    else check_eq("frame", cap, exp_q.pop_front());
                    gap_len   = 0;
                    gap_valid = 1;
                end
                gap_len++;
            end
            prev_ss   = spi_ss;
            prev_sck  = spi_sck;
            prev_mosi = spi_mosi;
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_eq("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic send(input logic [1:0] cmd, input logic [18:0] addr,
                        input logic [7:0] wdata, input logic [31:0] exp_frame);
        @(negedge clk);
        exp_q.push_back(exp_frame);
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int target);
        int n = 0;
        while (rsp_count < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_eq(tag, 32'(rsp_count), 32'(target));
    endtask

    // Back-to-back table: req_valid stays high across all six commands.
    logic [1:0]  bb_cmd  [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01};
    logic [18:0] bb_addr [6] = '{19'h00000, 19'h7FFFF, 19'h00000, 19'h12345, 19'h00000, 19'h00001};
    logic [7:0]  bb_wdata[6] = '{8'hFF, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00};
    logic [31:0] bb_frame[6] = '{32'h00000FF0, 32'hFFFFF000, 32'hFFFFFF00,
                                 32'h2468AA50, 32'hFFFFFFFF, 32'h00003000};

    // ---------------- stimulus ----------------
    initial begin
        int base;

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_ss", 32'(spi_ss), 32'd1);
        check_eq("rst_sck", 32'(spi_sck), 32'd0);
        check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rdata", 32'(rsp_rdata), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        #1 check_eq("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq("ready_after_edge", 32'(req_ready), 32'd1);

        // Write.
        miso_word = 32'h0000_005A;
        send(2'b00, 19'h51234, 8'h89, 32'hA2468890);
        wait_rsp("rsp_write", 1);
        check_eq("rdata_write", 32'(rsp_rdata), 32'h5A);

        // Read with slave returning 0x42.
        miso_word = 32'h0000_0042;
        send(2'b01, 19'h70F0F, 8'h00, 32'hE1E1F000);
        wait_rsp("rsp_read", 2);
        check_eq("rdata_read", 32'(rsp_rdata), 32'h42);
        repeat (20) @(negedge clk);
        check_eq("rdata_hold", 32'(rsp_rdata), 32'h42);

        // Lock then unlock; gap is checked by the monitor.
        miso_word = 32'hFFFF_FFC3;
        send(2'b10, 19'h00000, 8'h00, 32'hFFFFFF00);
        send(2'b11, 19'h00000, 8'h00, 32'hFFFFFFFF);
        wait_rsp("rsp_lock_unlock", 4);
        check_eq("rdata_unlock", 32'(rsp_rdata), 32'hC3);

        // Six back-to-back commands with req_valid held high.
        miso_word = 32'h0000_0011;
        base = rsp_count;
        @(negedge clk);
        for (int i = 0; i < 6; i++) exp_q.push_back(bb_frame[i]);
        req_cmd = bb_cmd[0]; req_addr = bb_addr[0]; req_wdata = bb_wdata[0];
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_ready();
            @(posedge clk);
            #1;
            if (i < 5) begin
                req_cmd = bb_cmd[i+1]; req_addr = bb_addr[i+1]; req_wdata = bb_wdata[i+1];
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        wait_rsp("rsp_b2b", base + 6);
        repeat (10) @(negedge clk);
        check_eq("b2b_no_extra", 32'(rsp_count), 32'(base + 6));
        check_eq("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a write, at the 17th SCK rising edge.
        miso_word = 32'h0000_0099;
        base = rsp_count;
        send(2'b00, 19'h2AAAA, 8'h3C, 32'h555543C0);
        begin
            int n = 0;
            while (cap_bits < 17 && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("abort_at_bit17", 32'(cap_bits), 32'd17);
        check_eq("abort_sck_high", 32'(spi_sck), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("abort_ss", 32'(spi_ss), 32'd1);
        check_eq("abort_sck", 32'(spi_sck), 32'd0);
        check_eq("abort_mosi", 32'(spi_mosi), 32'd0);
        check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("abort_no_rsp", 32'(rsp_count), 32'(base));
        check_eq("abort_rdata_cleared", 32'(rsp_rdata), 32'd0);

        // Clean frame after the abort.
        miso_word = 32'h0000_0077;
        send(2'b00, 19'h0ABCD, 8'h11, 32'h1579A110);
        wait_rsp("rsp_after_abort", base + 1);
        check_eq("rdata_after_abort", 32'(rsp_rdata), 32'h77);

        // Final report.
        repeat (10) @(negedge clk);
        check_eq("protocol_violations", 32'(proto_viol), 32'd0);
        check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
